// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcode encodings and the fetch sequencer state type.
package riscv_pkg;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] U_TYPE      = 7'b0110111;
  localparam logic [6:0] I_TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE      = 7'b0100011;
  localparam logic [6:0] B_TYPE      = 7'b1100011;
  localparam logic [6:0] JAL         = 7'b1101111;
  localparam logic [6:0] JALR        = 7'b1100111;
  localparam logic [6:0] HALT        = 7'b1111111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Owns the PC, issues one instruction-memory read at a time and presents the
// returned word to decode; the controller's verdicts pick the next PC.
module fetch_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            halt,
  output logic            halted,
  output logic [31:0]     retire_count
);

  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] inst_pc_q;
  logic [31:0]     inst_q;
  logic [31:0]     retire_q;
  logic            req_q, ival_q, halted_q;

  // Next PC for a non-halting handshake; redirect targets are forced word-aligned.
  always_comb begin
    pc_d = pc_q + PC_W'(4);
    if (redirect_valid) pc_d = {redirect_target[PC_W-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      retire_q  <= '0;
      req_q     <= 1'b0;
      ival_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            inst_q    <= imem_rsp_data;
            inst_pc_q <= pc_q;
            ival_q    <= 1'b1;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            retire_q <= retire_q + 32'd1;
            ival_q   <= 1'b0;
            // Halt outranks any redirect raised by the same instruction.
            if (halt) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_q    <= pc_d;
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
        end
        HALTED: ;
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          ival_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_q;
  assign imem_addr      = (state_q == IDLE) ? '0 : pc_q;
  assign inst_valid     = ival_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign halted         = halted_q;
  assign retire_count   = retire_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a 32-bit instance for sequencing, redirect,
// backpressure, halt and reset cases, and an 8-bit instance for PC wrap.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt, halted;
  logic [31:0] retire_count;

  logic        w_req_valid, w_req_ready, w_rsp_valid, w_inst_valid, w_inst_ready;
  logic [7:0]  w_addr, w_inst_pc;
  logic [31:0] w_rsp_data, w_inst, w_retire;
  logic        w_halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt(halt), .halted(halted), .retire_count(retire_count)
  );

  fetch_sequencer #(.PC_W(8), .RESET_PC(8'hFC)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .inst_valid(w_inst_valid),
    .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc),
    .redirect_valid(1'b0), .redirect_target(8'h00),
    .halt(1'b0), .halted(w_halted), .retire_count(w_retire)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_valid_seen", 32'(imem_req_valid), 32'd1);
  endtask

  // Takes one fetch from REQ to HOLD; wait_pulse raises halt/redirect during WAIT.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input bit wait_pulse);
    wait_req();
    check_eq("imem_addr", imem_addr, exp_addr);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check_eq("req_drop_in_wait", 32'(imem_req_valid), 32'd0);
    if (wait_pulse) begin
      redirect_valid  = 1'b1;
      redirect_target = 32'h80;
      halt            = 1'b1;
      @(negedge clk);
      redirect_valid  = 1'b0;
      halt            = 1'b0;
      check_eq("wait_pulse_no_hold", 32'(inst_valid), 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check_eq("inst_valid", 32'(inst_valid), 32'd1);
    check_eq("inst", inst, word);
    check_eq("inst_pc", inst_pc, exp_addr);
  endtask

  task automatic consume(input bit redir, input logic [31:0] target, input bit hlt);
    redirect_valid  = redir;
    redirect_target = target;
    halt            = hlt;
    inst_ready      = 1'b1;
    @(negedge clk);
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    check_eq("inst_valid_drop", 32'(inst_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0; halt = 1'b0;
    w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0; w_inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Reset state, observed while still in IDLE.
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_retire", retire_count, 32'd0);

    // Sequential fetch, with a halt/redirect pulse in WAIT that must be ignored.
    fetch(32'h0, 32'h0000_0013, 1'b0);
    consume(1'b0, 32'h0, 1'b0);
    check_eq("retire_1", retire_count, 32'd1);
    fetch(32'h4, 32'h0040_0093, 1'b1);
    consume(1'b0, 32'h0, 1'b0);
    check_eq("retire_2", retire_count, 32'd2);
    fetch(32'h8, 32'h0000_0063, 1'b0);
    consume(1'b1, 32'h43, 1'b0);
    check_eq("retire_3", retire_count, 32'd3);

    // Redirect to 0x43 lands at 0x40; memory stalls 3 cycles, decode stalls 2.
    wait_req();
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_req_held", 32'(imem_req_valid), 32'd1);
      check_eq("bp_addr_held", imem_addr, 32'h40);
      @(negedge clk);
    end
    fetch(32'h40, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("bp_inst_valid", 32'(inst_valid), 32'd1);
      check_eq("bp_inst_held", inst, 32'hDEAD_BEEF);
      check_eq("bp_retire_held", retire_count, 32'd3);
      check_eq("bp_no_dup_req", 32'(imem_req_valid), 32'd0);
    end
    consume(1'b0, 32'h0, 1'b0);
    check_eq("bp_retire_once", retire_count, 32'd4);

    // Halt wins over a simultaneous redirect and still retires.
    fetch(32'h44, 32'h0000_007F, 1'b0);
    consume(1'b1, 32'h100, 1'b1);
    check_eq("halted", 32'(halted), 32'd1);
    check_eq("halt_retire", retire_count, 32'd5);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("halt_no_req", 32'(imem_req_valid), 32'd0);
      check_eq("halt_no_inst", 32'(inst_valid), 32'd0);
      check_eq("halt_stays", 32'(halted), 32'd1);
    end
    imem_req_ready = 1'b0;

    // Reset while a fetch is in WAIT; the late response must be discarded.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_req();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rw_idle_req", 32'(imem_req_valid), 32'd0);
    check_eq("rw_halted", 32'(halted), 32'd0);
    check_eq("rw_retire", retire_count, 32'd0);
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check_eq("rw_stale_ignored", 32'(inst_valid), 32'd0);
    check_eq("rw_inst_clear", inst, 32'h0);
    fetch(32'h0, 32'h1234_5678, 1'b0);

    // PC wrap on the 8-bit instance: 0xFC + 4 -> 0x00.
    begin
      int n = 0;
      while (!w_req_valid && n < 20) begin @(negedge clk); n++; end
    end
    check_eq("wrap_req", 32'(w_req_valid), 32'd1);
    check_eq("wrap_addr_fc", 32'(w_addr), 32'h0000_00FC);
    w_req_ready = 1'b1;
    @(negedge clk);
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b1;
    w_rsp_data  = 32'h0000_0013;
    @(negedge clk);
    w_rsp_valid = 1'b0;
    check_eq("wrap_inst_pc", 32'(w_inst_pc), 32'h0000_00FC);
    w_inst_ready = 1'b1;
    @(negedge clk);
    w_inst_ready = 1'b0;
    check_eq("wrap_req_again", 32'(w_req_valid), 32'd1);
    check_eq("wrap_addr_00", 32'(w_addr), 32'h0000_0000);
    check_eq("wrap_retire", w_retire, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
